i2c_multi_addr_detector: RTL and testbench

I2C_MULTI_ADDR_DETECTOR -- requirements
Module: i2c_multi_addr_detector

---
 rtl/i2c_multi_addr_detector.sv | 256 +++++++++++++++++++++++++
 tb/tb_i2c_multi_addr_detector.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_multi_addr_detector.sv
// i2c_multi_addr_detector
//   Passive I2C slave front end that recognises up to NUM_ADDR 7-bit slave
//   addresses (plus an optional general call). It ACKs matching address
//   bytes, ACKs every byte the master writes, and monitors master reads.
//   The slave never drives read data; it only tracks the master's ACK/NACK.
//
// Ports
//   clk        system clock, at least 8x the SCL rate
//   rst_n      asynchronous active-low reset
//   scl_in     raw bus SCL, asynchronous to clk
//   sda_in     raw bus SDA, asynchronous to clk
//   sda_oe     1 = pull SDA low (ACK)
//   wr_enable  addressed, master write in progress
//   rd_enable  addressed, master read in progress
//   hit_idx    index of the matched ADDR_LIST entry (0 on general call)
//   gcall      current transfer is a general call
//   rx_data    last received data byte, MSB first
//   rx_valid   one-clk pulse when rx_data updates
//   start_det  one-clk pulse on START or repeated START
//   stop_det   one-clk pulse on STOP
//
// state    | meaning
// ---------+-------------------------------------------------
// IDLE     | bus free, waiting for START
// ADDR     | shifting in 7 address bits + R/W
// ADDR_ACK | driving ACK for a matched address
// RX_DATA  | shifting in a byte written by the master
// RX_ACK   | driving ACK for a received byte
// TX_MON   | master read: counting bits, watching master ACK
// IGNORE   | not addressed, waiting for START/Sr or STOP
module i2c_multi_addr_detector #(
  parameter int                    NUM_ADDR  = 2,
  parameter logic [NUM_ADDR*7-1:0] ADDR_LIST = {7'h11, 7'h10},
  parameter bit                    GCALL_EN  = 1'b1,
  parameter int                    FILT_LEN  = 3,
  localparam int                   IW        = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          scl_in,
  input  logic          sda_in,
  output logic          sda_oe,
  output logic          wr_enable,
  output logic          rd_enable,
  output logic [IW-1:0] hit_idx,
  output logic          gcall,
  output logic [7:0]    rx_data,
  output logic          rx_valid,
  output logic          start_det,
  output logic          stop_det
);

  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_MON, IGNORE} state_e;

  logic [1:0]          scl_s_q, scl_s_d, sda_s_q, sda_s_d;
  logic [FILT_LEN-1:0] scl_h_q, scl_h_d, sda_h_q, sda_h_d;
  logic                scl_f_q, scl_f_d, sda_f_q, sda_f_d;
  logic                scl_p_q, sda_p_q;
  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [7:0]          sh_q, sh_d;
  logic                sda_oe_q, sda_oe_d, wr_q, wr_d, rd_q, rd_d, gcall_q, gcall_d;
  logic [IW-1:0]       hit_idx_q, hit_idx_d;
  logic [7:0]          rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d, start_q, stop_q;

  logic scl_rise, scl_fall, start_ev, stop_ev;
  logic addr_hit, addr_gc;
  logic [IW-1:0] addr_idx;

  // Synchronizers feed a shift history; the filtered level only moves once
  // FILT_LEN consecutive samples agree.
  always_comb begin
    scl_s_d = {scl_s_q[0], scl_in};
    sda_s_d = {sda_s_q[0], sda_in};
    scl_h_d = (scl_h_q << 1) | FILT_LEN'(scl_s_q[1]);
    sda_h_d = (sda_h_q << 1) | FILT_LEN'(sda_s_q[1]);
    scl_f_d = scl_f_q;
    sda_f_d = sda_f_q;
    if (&scl_h_d)       scl_f_d = 1'b1;
    else if (~|scl_h_d) scl_f_d = 1'b0;
    if (&sda_h_d)       sda_f_d = 1'b1;
    else if (~|sda_h_d) sda_f_d = 1'b0;
  end

  assign scl_rise = scl_f_q & ~scl_p_q;
  assign scl_fall = ~scl_f_q & scl_p_q;
  // SCL must be high on both sides of the SDA edge to count as START/STOP.
  assign start_ev = scl_f_q & scl_p_q & sda_p_q & ~sda_f_q;
  assign stop_ev  = scl_f_q & scl_p_q & ~sda_p_q & sda_f_q;

  // Descending scan so the lowest matching index wins; general call only
  // when no list entry matched. sh_q holds the address byte through ADDR_ACK.
  always_comb begin
    addr_hit = 1'b0;
    addr_idx = '0;
    for (int i = NUM_ADDR - 1; i >= 0; i--) begin
      if (sh_q[7:1] == ADDR_LIST[7*i +: 7]) begin
        addr_hit = 1'b1;
        addr_idx = IW'(i);
      end
    end
    addr_gc = !addr_hit && GCALL_EN && (sh_q[7:1] == 7'h00) && !sh_q[0];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    sda_oe_d   = sda_oe_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    gcall_d    = gcall_q;
    hit_idx_d  = hit_idx_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    if (stop_ev || start_ev) begin
      state_d  = stop_ev ? IDLE : ADDR;
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
      wr_d     = 1'b0;
      rd_d     = 1'b0;
      gcall_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        ADDR: begin
          if (scl_rise) begin
            sh_d  = {sh_q[6:0], sda_f_q};
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            cnt_d = 4'd0;
            if (addr_hit || addr_gc) begin
              sda_oe_d = 1'b1;
              state_d  = ADDR_ACK;
            end else begin
              state_d  = IGNORE;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd1) begin
            sda_oe_d  = 1'b0;
            cnt_d     = 4'd0;
            hit_idx_d = addr_idx;
            gcall_d   = addr_gc;
            if (sh_q[0]) begin
              rd_d    = 1'b1;
              state_d = TX_MON;
            end else begin
              wr_d    = 1'b1;
              state_d = RX_DATA;
            end
          end
        end
        RX_DATA: begin
          if (scl_rise) begin
            sh_d  = {sh_q[6:0], sda_f_q};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              rx_data_d  = {sh_q[6:0], sda_f_q};
              rx_valid_d = 1'b1;
            end
          end else if (scl_fall && cnt_q == 4'd8) begin
            sda_oe_d = 1'b1;
            cnt_d    = 4'd0;
            state_d  = RX_ACK;
          end
        end
        RX_ACK: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd1) begin
            sda_oe_d = 1'b0;
            cnt_d    = 4'd0;
            state_d  = RX_DATA;
          end
        end
        TX_MON: begin
          if (scl_rise) begin
            if (cnt_q == 4'd8) begin
              cnt_d = 4'd0;
              if (sda_f_q) begin
                rd_d    = 1'b0;
                state_d = IGNORE;
              end
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        IGNORE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_s_q    <= '1;
      sda_s_q    <= '1;
      scl_h_q    <= '1;
      sda_h_q    <= '1;
      scl_f_q    <= 1'b1;
      sda_f_q    <= 1'b1;
      scl_p_q    <= 1'b1;
      sda_p_q    <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      sh_q       <= 8'h00;
      sda_oe_q   <= 1'b0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      gcall_q    <= 1'b0;
      hit_idx_q  <= '0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_s_q    <= scl_s_d;
      sda_s_q    <= sda_s_d;
      scl_h_q    <= scl_h_d;
      sda_h_q    <= sda_h_d;
      scl_f_q    <= scl_f_d;
      sda_f_q    <= sda_f_d;
      scl_p_q    <= scl_f_q;
      sda_p_q    <= sda_f_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      sda_oe_q   <= sda_oe_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      gcall_q    <= gcall_d;
      hit_idx_q  <= hit_idx_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      start_q    <= start_ev;
      stop_q     <= stop_ev;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign wr_enable = wr_q;
  assign rd_enable = rd_q;
  assign gcall     = gcall_q;
  assign hit_idx   = hit_idx_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign start_det = start_q;
  assign stop_det  = stop_q;

endmodule

// File: tb/tb_i2c_multi_addr_detector.sv
// Directed bench for i2c_multi_addr_detector with the default parameters
// (addresses 7'h10 at index 0 and 7'h11 at index 1, general call on).
// The bus is modelled as wired-AND: the master drives sda_m, the DUT pulls
// low through sda_oe.
module tb_i2c_multi_addr_detector;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       scl_in, sda_in;
  logic       sda_oe, wr_enable, rd_enable, gcall, rx_valid, start_det, stop_det;
  logic [0:0] hit_idx;
  logic [7:0] rx_data;

  assign scl_in = scl_m;
  assign sda_in = sda_m & ~sda_oe;

  i2c_multi_addr_detector dut (
    .clk(clk), .rst_n(rst_n), .scl_in(scl_in), .sda_in(sda_in),
    .sda_oe(sda_oe), .wr_enable(wr_enable), .rd_enable(rd_enable),
    .hit_idx(hit_idx), .gcall(gcall), .rx_data(rx_data), .rx_valid(rx_valid),
    .start_det(start_det), .stop_det(stop_det)
  );

  always #5 clk = ~clk;

  int vecs = 0, errs = 0;
  int n_start = 0, n_stop = 0, n_rxv = 0, n_oe = 0, n_both = 0;

  always @(negedge clk) begin
    if (start_det) n_start++;
    if (stop_det) n_stop++;
    if (rx_valid) n_rxv++;
    if (sda_oe) n_oe++;
    if (wr_enable && rd_enable) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL clock; returns sda_oe sampled in the middle of the high phase.
  task automatic clk_bit(input logic b, output logic oe_mid);
    tick(10); sda_m = b; tick(10); scl_m = 1'b1; tick(10); oe_mid = sda_oe; tick(10); scl_m = 1'b0;
  endtask

  // Eight data bits then a ninth bit b9 (1 = released, 0 = master ACK).
  task automatic xfer_byte(input logic [7:0] d, input logic b9, output logic ack);
    logic x;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], x);
    clk_bit(b9, ack);
  endtask

  task automatic start_c();
    sda_m = 1'b0; tick(20); scl_m = 1'b0;
  endtask

  task automatic rstart_c();
    tick(10); sda_m = 1'b1; tick(10); scl_m = 1'b1; tick(20); sda_m = 1'b0; tick(20); scl_m = 1'b0;
  endtask

  task automatic stop_c();
    tick(10); sda_m = 1'b0; tick(10); scl_m = 1'b1; tick(20); sda_m = 1'b1; tick(20);
  endtask

  initial begin
    logic ack, x;
    int s0, p0, v0, o0;

    // reset values
    tick(5);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_wr", wr_enable, 0);
    check("rst_rd", rd_enable, 0);
    check("rst_gcall", gcall, 0);
    check("rst_hit_idx", hit_idx, 0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_start_det", start_det, 0);
    check("rst_stop_det", stop_det, 0);
    rst_n = 1'b1;
    tick(10);

    // write 7'h10, byte A5, STOP
    s0 = n_start; p0 = n_stop; v0 = n_rxv;
    start_c();
    xfer_byte(8'h20, 1'b1, ack);
    check("w10_addr_ack", ack, 1);
    tick(10);
    check("w10_wr", wr_enable, 1);
    check("w10_rd", rd_enable, 0);
    check("w10_hit", hit_idx, 0);
    check("w10_gcall", gcall, 0);
    xfer_byte(8'hA5, 1'b1, ack);
    check("w10_data_ack", ack, 1);
    check("w10_rx_data", rx_data, 8'hA5);
    check("w10_rx_valid_cnt", n_rxv - v0, 1);
    stop_c();
    check("w10_stop_cnt", n_stop - p0, 1);
    check("w10_start_cnt", n_start - s0, 1);
    check("w10_wr_after_stop", wr_enable, 0);

    // read 7'h11: ACK, ACK, NACK
    start_c();
    xfer_byte(8'h23, 1'b1, ack);
    check("r11_addr_ack", ack, 1);
    tick(10);
    check("r11_rd", rd_enable, 1);
    check("r11_wr", wr_enable, 0);
    check("r11_hit", hit_idx, 1);
    o0 = n_oe;
    xfer_byte(8'h5A, 1'b0, ack);
    check("r11_b1_rd", rd_enable, 1);
    xfer_byte(8'hC3, 1'b0, ack);
    check("r11_b2_rd", rd_enable, 1);
    xfer_byte(8'h99, 1'b1, ack);
    tick(10);
    check("r11_nack_rd", rd_enable, 0);
    xfer_byte(8'h00, 1'b0, ack);
    check("r11_ignore_rd", rd_enable, 0);
    check("r11_oe_cycles", n_oe - o0, 0);
    stop_c();

    // unmatched address 7'h33
    o0 = n_oe; v0 = n_rxv;
    start_c();
    xfer_byte(8'h66, 1'b1, ack);
    check("a33_addr_ack", ack, 0);
    tick(10);
    check("a33_wr", wr_enable, 0);
    check("a33_rd", rd_enable, 0);
    xfer_byte(8'h12, 1'b1, ack);
    check("a33_data_ack", ack, 0);
    check("a33_oe_cycles", n_oe - o0, 0);
    check("a33_rx_valid_cnt", n_rxv - v0, 0);
    stop_c();

    // general call write, then general call read
    start_c();
    xfer_byte(8'h00, 1'b1, ack);
    check("gc_w_ack", ack, 1);
    tick(10);
    check("gc_w_gcall", gcall, 1);
    check("gc_w_wr", wr_enable, 1);
    check("gc_w_hit", hit_idx, 0);
    xfer_byte(8'h81, 1'b1, ack);
    check("gc_w_data_ack", ack, 1);
    check("gc_w_rx_data", rx_data, 8'h81);
    stop_c();
    check("gc_gcall_after_stop", gcall, 0);
    start_c();
    xfer_byte(8'h01, 1'b1, ack);
    check("gc_r_ack", ack, 0);
    tick(10);
    check("gc_r_rd", rd_enable, 0);
    check("gc_r_gcall", gcall, 0);
    stop_c();

    // write 7'h10, Sr, read 7'h11
    s0 = n_start;
    start_c();
    xfer_byte(8'h20, 1'b1, ack);
    check("sr_w_ack", ack, 1);
    xfer_byte(8'h3C, 1'b1, ack);
    check("sr_w_data_ack", ack, 1);
    check("sr_rx_data", rx_data, 8'h3C);
    check("sr_wr_before", wr_enable, 1);
    rstart_c();
    check("sr_wr_after", wr_enable, 0);
    check("sr_start_cnt", n_start - s0, 2);
    xfer_byte(8'h23, 1'b1, ack);
    check("sr_r_ack", ack, 1);
    tick(10);
    check("sr_rd", rd_enable, 1);
    check("sr_hit", hit_idx, 1);
    check("sr_wr", wr_enable, 0);
    xfer_byte(8'hFF, 1'b1, ack);
    stop_c();

    // 1-clk SDA glitch while SCL is high
    s0 = n_start; p0 = n_stop;
    tick(5);
    sda_m = 1'b0; tick(1); sda_m = 1'b1;
    tick(30);
    check("glitch_start_cnt", n_start - s0, 0);
    check("glitch_stop_cnt", n_stop - p0, 0);

    // reset pulsed while the address ACK is being driven
    start_c();
    for (int i = 7; i >= 0; i--) clk_bit(i == 5, x);
    tick(10); sda_m = 1'b1; tick(10); scl_m = 1'b1; tick(10);
    check("rst_mid_oe_before", sda_oe, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_oe", sda_oe, 0);
    check("rst_mid_wr", wr_enable, 0);
    check("rst_mid_rx_data", rx_data, 8'h00);
    check("rst_mid_gcall", gcall, 0);
    tick(3);
    rst_n = 1'b1;
    tick(10);
    scl_m = 1'b0;
    o0 = n_oe;
    xfer_byte(8'hA5, 1'b1, ack);
    check("rst_mid_no_ack", ack, 0);
    check("rst_mid_oe_cycles", n_oe - o0, 0);
    check("rst_mid_wr_after", wr_enable, 0);
    stop_c();
    start_c();
    xfer_byte(8'h20, 1'b1, ack);
    check("rst_fresh_ack", ack, 1);
    stop_c();

    check("wr_rd_exclusive", n_both, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
